// File: rtl/svc_rv_ras.sv
// svc_rv_ras: return address stack with snapshot/restore for front-end return prediction
module svc_rv_ras #(
    parameter int XLEN = 32,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             push_en,
    input  logic [XLEN-1:0]  push_addr,
    input  logic             pop_en,
    input  logic             restore_en,
    input  logic [PTR_W-1:0] restore_ptr,
    input  logic [CNT_W-1:0] restore_count,
    output logic [PTR_W-1:0] snap_ptr,
    output logic [CNT_W-1:0] snap_count,
    output logic             ras_valid_if,
    output logic [XLEN-1:0]  ras_target_if
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] ptr_inc;
    logic             upd;
    logic             wr;
    logic [PTR_W-1:0] wr_addr;
    always_comb begin
        ptr_inc = ptr + 1'b1;
        upd     = rst_n && !restore_en && !stall;
        wr      = upd && push_en;
        // a coroutine swap overwrites the current top in place
        wr_addr = pop_en ? ptr : ptr_inc;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (restore_en) begin
            ptr   <= restore_ptr;
            count <= restore_count;
        end else if (upd) begin
            if (push_en && !pop_en) begin
                ptr   <= ptr_inc;
                count <= (count == FULL) ? count : count + 1'b1;
            end else if (pop_en && !push_en && count != '0) begin
                ptr   <= ptr - 1'b1;
                count <= count - 1'b1;
            end else if (push_en && pop_en && count == '0) begin
                count <= CNT_W'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wr_addr] <= push_addr;
    end
    assign ras_valid_if  = (count != '0);
    assign ras_target_if = ras_valid_if ? mem[ptr] : '0;
    assign snap_ptr      = ptr;
    assign snap_count    = count;
endmodule

// File: tb/tb_svc_rv_ras.sv
// tb_svc_rv_ras: directed self-checking bench for the return address stack
module tb_svc_rv_ras;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        stall = 0;
    logic        push_en = 0;
    logic [31:0] push_addr = 0;
    logic        pop_en = 0;
    logic        restore_en = 0;
    logic [2:0]  restore_ptr = 0;
    logic [3:0]  restore_count = 0;
    logic [2:0]  snap_ptr;
    logic [3:0]  snap_count;
    logic        ras_valid_if;
    logic [31:0] ras_target_if;
    int tests = 0;
    int fails = 0;

    svc_rv_ras #(.XLEN(32), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .push_en(push_en),
        .push_addr(push_addr), .pop_en(pop_en), .restore_en(restore_en),
        .restore_ptr(restore_ptr), .restore_count(restore_count),
        .snap_ptr(snap_ptr), .snap_count(snap_count),
        .ras_valid_if(ras_valid_if), .ras_target_if(ras_target_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        stall = 0; push_en = 0; pop_en = 0; restore_en = 0; rst_n = 1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
    endtask

    task automatic push(input logic [31:0] a);
        push_en = 1; push_addr = a;
        step();
    endtask

    task automatic pop();
        pop_en = 1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) step();
        tests++; if (ras_valid_if !== 1'b0) begin fails++; $display("FAIL reset_valid got %0h exp 0", ras_valid_if); end
        tests++; if (ras_target_if !== 32'h0) begin fails++; $display("FAIL reset_target got %0h exp 0", ras_target_if); end
        tests++; if (snap_count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", snap_count); end
        tests++; if (snap_ptr !== 3'd0) begin fails++; $display("FAIL reset_ptr got %0d exp 0", snap_ptr); end
    endtask

    task automatic test_lifo();
        push(32'h100); push(32'h200); push(32'h300);
        tests++; if (ras_target_if !== 32'h300) begin fails++; $display("FAIL lifo_top got %0h exp 300", ras_target_if); end
        tests++; if (snap_count !== 4'd3) begin fails++; $display("FAIL lifo_count got %0d exp 3", snap_count); end
        tests++; if (snap_ptr !== 3'd3) begin fails++; $display("FAIL lifo_ptr got %0d exp 3", snap_ptr); end
        pop();
        tests++; if (ras_target_if !== 32'h200) begin fails++; $display("FAIL lifo_pop1 got %0h exp 200", ras_target_if); end
        pop();
        tests++; if (ras_target_if !== 32'h100) begin fails++; $display("FAIL lifo_pop2 got %0h exp 100", ras_target_if); end
        pop();
        tests++; if (ras_valid_if !== 1'b0) begin fails++; $display("FAIL lifo_empty_valid got %0h exp 0", ras_valid_if); end
        tests++; if (ras_target_if !== 32'h0) begin fails++; $display("FAIL lifo_empty_target got %0h exp 0", ras_target_if); end
        pop();
        tests++; if (snap_count !== 4'd0) begin fails++; $display("FAIL underflow_count got %0d exp 0", snap_count); end
        tests++; if (snap_ptr !== 3'd0) begin fails++; $display("FAIL underflow_ptr got %0d exp 0", snap_ptr); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) push(32'h1000 + 32'(4 * i));
        tests++; if (snap_count !== 4'd8) begin fails++; $display("FAIL ovf_count got %0d exp 8", snap_count); end
        tests++; if (snap_ptr !== 3'd2) begin fails++; $display("FAIL ovf_ptr got %0d exp 2", snap_ptr); end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (ras_target_if !== 32'h1024 - 32'(4 * k)) begin
                fails++; $display("FAIL ovf_pop%0d got %0h exp %0h", k, ras_target_if, 32'h1024 - 32'(4 * k));
            end
            pop();
        end
        tests++; if (ras_valid_if !== 1'b0) begin fails++; $display("FAIL ovf_drained_valid got %0h exp 0", ras_valid_if); end
        tests++; if (snap_ptr !== 3'd2) begin fails++; $display("FAIL ovf_drained_ptr got %0d exp 2", snap_ptr); end
    endtask

    task automatic test_push_pop();
        do_reset();
        push(32'h80); push(32'h100);
        push_en = 1; pop_en = 1; push_addr = 32'h500;
        step();
        tests++; if (ras_target_if !== 32'h500) begin fails++; $display("FAIL swap_target got %0h exp 500", ras_target_if); end
        tests++; if (snap_count !== 4'd2) begin fails++; $display("FAIL swap_count got %0d exp 2", snap_count); end
        tests++; if (snap_ptr !== 3'd2) begin fails++; $display("FAIL swap_ptr got %0d exp 2", snap_ptr); end
        pop();
        tests++; if (ras_target_if !== 32'h80) begin fails++; $display("FAIL swap_below got %0h exp 80", ras_target_if); end
        pop();
        push_en = 1; pop_en = 1; push_addr = 32'h700;
        step();
        tests++; if (ras_valid_if !== 1'b1) begin fails++; $display("FAIL swap_empty_valid got %0h exp 1", ras_valid_if); end
        tests++; if (ras_target_if !== 32'h700) begin fails++; $display("FAIL swap_empty_target got %0h exp 700", ras_target_if); end
        tests++; if (snap_count !== 4'd1) begin fails++; $display("FAIL swap_empty_count got %0d exp 1", snap_count); end
        tests++; if (snap_ptr !== 3'd0) begin fails++; $display("FAIL swap_empty_ptr got %0d exp 0", snap_ptr); end
    endtask

    task automatic test_restore();
        logic [2:0] p;
        logic [3:0] c;
        do_reset();
        push(32'hA0);
        p = snap_ptr; c = snap_count;
        tests++; if (p !== 3'd1 || c !== 4'd1) begin fails++; $display("FAIL snap got %0d/%0d exp 1/1", p, c); end
        push(32'hB0); pop(); pop();
        tests++; if (ras_valid_if !== 1'b0) begin fails++; $display("FAIL wrong_path_valid got %0h exp 0", ras_valid_if); end
        restore_en = 1; restore_ptr = p; restore_count = c; push_en = 1; push_addr = 32'hC0;
        step();
        tests++; if (ras_target_if !== 32'hA0) begin fails++; $display("FAIL restore_target got %0h exp a0", ras_target_if); end
        tests++; if (snap_count !== 4'd1) begin fails++; $display("FAIL restore_count got %0d exp 1", snap_count); end
        tests++; if (snap_ptr !== 3'd1) begin fails++; $display("FAIL restore_ptr got %0d exp 1", snap_ptr); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            stall = 1; push_en = 1; push_addr = 32'h900;
            step();
            tests++; if (ras_target_if !== 32'hA0) begin fails++; $display("FAIL stall_push%0d_target got %0h exp a0", i, ras_target_if); end
            tests++; if (snap_count !== 4'd1 || snap_ptr !== 3'd1) begin fails++; $display("FAIL stall_push%0d_state got %0d/%0d exp 1/1", i, snap_ptr, snap_count); end
        end
        stall = 1; pop_en = 1;
        step();
        tests++; if (snap_count !== 4'd1 || snap_ptr !== 3'd1) begin fails++; $display("FAIL stall_pop_state got %0d/%0d exp 1/1", snap_ptr, snap_count); end
        stall = 1; restore_en = 1; restore_ptr = 3'd2; restore_count = 4'd2;
        step();
        tests++; if (ras_target_if !== 32'hB0) begin fails++; $display("FAIL stall_restore_target got %0h exp b0", ras_target_if); end
        tests++; if (snap_count !== 4'd2 || snap_ptr !== 3'd2) begin fails++; $display("FAIL stall_restore_state got %0d/%0d exp 2/2", snap_ptr, snap_count); end
        push(32'hD0);
        tests++; if (ras_target_if !== 32'hD0 || snap_count !== 4'd3) begin fails++; $display("FAIL post_stall_push got %0h/%0d exp d0/3", ras_target_if, snap_count); end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_push_pop();
        test_restore();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/svc_rv_ras.md
# svc_rv_ras

Return address stack for the RISC-V core's front end. Sits upstream of the instruction fetch stage. It predicts return targets from call/return events decoded in ID and drives `ras_valid_if` / `ras_target_if` to the fetch stage. It is a circular buffer with a top-of-stack pointer and an occupancy counter, and supports snapshot/restore so mispredicted-path pushes and pops can be undone on redirect.

## Interface

Parameters:
- `XLEN`, 32, address width.
- `DEPTH`, 8, number of entries; power of two, ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`, localparam; pointer width.
- `CNT_W`, `$clog2(DEPTH+1)`, localparam; counter width.

Ports:
- `clk`, input, 1, clock; single clock domain.
- `rst_n`, input, 1, reset; synchronous, active-low.
- `stall`, input, 1, blocks push/pop updates; restore is still honoured.
- `push_en`, input, 1, call decoded in ID (JAL/JALR with rd ∈ {x1, x5}).
- `push_addr`, input, XLEN, return address for the call (pc_plus4 of the call).
- `pop_en`, input, 1, return decoded in ID (JALR rs1 ∈ {x1, x5}, rd = x0).
- `restore_en`, input, 1, redirect recovery; reload pointer and count.
- `restore_ptr`, input, PTR_W, snapshot pointer to reload.
- `restore_count`, input, CNT_W, snapshot count to reload.
- `snap_ptr`, output, PTR_W, current top-of-stack pointer, carried down the pipe as a snapshot.
- `snap_count`, output, CNT_W, current occupancy, carried as a snapshot.
- `ras_valid_if`, output, 1, stack non-empty; prediction is usable.
- `ras_target_if`, output, XLEN, top-of-stack return address.

## Operation

- State:
  - `mem[DEPTH]` of XLEN; not reset.
  - `ptr` indexes the current top entry.
  - `count` is in 0..DEPTH.
- Outputs:
  - `ras_valid_if = (count != 0)`.
  - `ras_target_if = ras_valid_if ? mem[ptr] : '0`.
  - `snap_ptr = ptr`; `snap_count = count`.
  - All outputs are combinational from registered state.
- Update priority, highest first:
  1. `restore_en`: `ptr <= restore_ptr`, `count <= restore_count` (caller guarantees `restore_count ≤ DEPTH`); `mem` is untouched; push/pop that cycle are ignored.
  2. `stall`: no state change.
  3. Push only: `ptr <= ptr+1` (mod DEPTH), `mem[ptr+1] <= push_addr`, `count <= min(count+1, DEPTH)`.
  4. Pop only:
     - `count > 0`: `ptr <= ptr-1` (mod DEPTH), `count <= count-1`.
     - `count == 0`: no change (underflow ignored).
  5. Push and pop together (coroutine swap):
     - `mem[ptr] <= push_addr`; `ptr` unchanged.
     - `count == 0`: `count <= 1`; otherwise `count` unchanged.
  6. Neither: hold.
- Overflow: a push at `count == DEPTH` wraps and overwrites the oldest entry; `count` stays DEPTH.
- Pointer arithmetic is modulo DEPTH using natural PTR_W wrap; there is no separate full flag.

## Timing

- Reset (`rst_n` low at a posedge): `ptr <= 0`, `count <= 0`. From the following cycle: `ras_valid_if = 0`, `ras_target_if = 0`, `snap_ptr = 0`, `snap_count = 0`.
- Reset mid-operation discards all entries logically; `mem` contents are don't-care because `count == 0` masks them.
- Latency: a push or pop sampled at edge N is visible on the outputs after edge N. There is no same-cycle bypass of `push_addr` to `ras_target_if`.
- Restore is effective after the sampling edge, the same as push/pop. Restore values override a concurrent push/pop and a concurrent `stall`.
- `stall` with `push_en` / `pop_en` asserted: events are dropped, not queued. The upstream stage re-presents them while stalled.
- No handshake; every input is a single-cycle qualifier sampled at each posedge.

## Test plan

- **Reset then idle.** Deassert reset, hold all inputs low 3 cycles → `ras_valid_if = 0`, `ras_target_if = 0`, `snap_count = 0`.
- **Push/pop LIFO.** Push 0x100, 0x200, 0x300 on consecutive cycles → target 0x300, `count = 3`. Pop → 0x200; pop → 0x100; pop → `valid = 0`, target 0. A fourth pop is ignored with `count = 0` and `ptr` unchanged.
- **Overflow wrap (DEPTH = 8).** Push 0x1000..0x1024 (10 entries) → `count = 8`, target 0x1024. Eight pops return 0x1024 down to 0x1008, then `valid = 0`.
- **Simultaneous push+pop.**
  - With 0x100 on top and `count = 2`: both asserted with push_addr 0x500 → target 0x500, `count = 2`, `ptr` unchanged.
  - From empty: both asserted with 0x700 → `valid = 1`, target 0x700, `count = 1`.
- **Restore after wrong path.** Push 0xA0, record snap (ptr P, count 1). Push 0xB0, then pop twice. Assert `restore_en` with (P, 1) plus a concurrent `push_en` → target 0xA0, `count = 1`; the push is ignored.
- **Stall.** `stall = 1` with `push_en` (0x900) for 2 cycles → state unchanged. `stall = 1` with `restore_en` → restore is applied.
